nibble_add_ctrl: RTL and testbench
==================================

NIBBLE_ADD_CTRL -- requirements
Module: nibble_add_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in 4-bit nibbles; operand width W = 4*N.
REQ-002 CLK  input  1  Single clock; all state SHALL change on its rising edge.
REQ-003 RST  input  1  Reset, asynchronous and active-high.
REQ-004 START  input  1  Request to begin an addition; sampled on the rising edge of CLK.
REQ-005 X  input  W  First operand; SHALL be captured on the START accept edge.
REQ-006 Y  input  W  Second operand; SHALL be captured on the START accept edge.
REQ-007 CIN  input  1  Carry-in; SHALL be captured on the START accept edge.
REQ-008 A  output  4  Current X nibble driven to the external 4-bit ripple-carry adder.
REQ-009 B  output  4  Current Y nibble driven to the external adder.
REQ-010 Ci  output  1  Carry driven to the external adder.
REQ-011 S  input  4  Sum nibble returned by the external adder; it is combinational from A, B and Ci.
REQ-012 Co  input  1  Carry-out returned by the external adder.
REQ-013 SUM  output  W  Registered result of the last completed addition.
REQ-014 COUT  output  1  Registered carry-out of the last completed addition.
REQ-015 OVF  output  1  Registered two's-complement overflow of the last completed addition.
REQ-016 BUSY  output  1  High while the addition is in progress (ADD state).
REQ-017 DONE  output  1  One-cycle pulse marking that SUM, COUT and OVF have been updated.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ADD and FIN.
REQ-019 In IDLE, START=1 at a rising edge SHALL perform all of the following:
- load X into the X shift register and Y into the Y shift register;
- load CIN into the carry register;
- clear the nibble counter;
- go to ADD.
REQ-020 START SHALL be ignored in ADD and FIN; operands presented then are not captured.
REQ-021 In ADD, A, B and Ci SHALL be driven directly from registers, with no combinational path from any input:
- A = X shift register [3:0];
- B = Y shift register [3:0];
- Ci = carry register.
REQ-022 At each ADD edge the block SHALL perform all of the following:
- shift S into the top nibble of the partial-sum register, which shifts right by 4;
- load Co into the carry register;
- shift the X and Y shift registers right by 4;
- increment the counter.
REQ-023 ADD SHALL last exactly N cycles; the edge that processes nibble N-1 SHALL perform all of the following:
- load SUM from the completed partial sum;
- load COUT from Co;
- load OVF = (X[W-1]==Y[W-1]) && (sum[W-1]!=X[W-1]), using the captured operands;
- go to FIN.
REQ-024 In FIN, DONE SHALL be 1 for exactly one cycle, after which the FSM SHALL return unconditionally to IDLE.
REQ-025 Latency: if START is accepted at edge k, DONE SHALL be high in the cycle following edge k+N, and the next START SHALL be accepted at edge k+N+2 at the earliest.
REQ-026 SUM, COUT and OVF SHALL hold their previous values during ADD and SHALL change only on the final ADD edge.
REQ-027 In IDLE and FIN, A, B and Ci SHALL be 0.
REQ-028 BUSY SHALL be 1 only in ADD, and DONE SHALL be 1 only in FIN; the two SHALL never be high together.
REQ-029 Arithmetic SHALL be unsigned modulo 2^W; wrap-around SHALL be reported only through COUT, with OVF reporting signed overflow.

Reset
REQ-030 While RST=1, the following SHALL take effect immediately, regardless of CLK, and be held:
- state = IDLE;
- all shift, partial-sum, counter and carry registers = 0;
- SUM = 0, COUT = 0, OVF = 0, BUSY = 0, DONE = 0, A = 0, B = 0, Ci = 0.
REQ-031 Reset asserted during ADD SHALL abort the addition: no DONE pulse, and SUM SHALL not be updated with partial data.
REQ-032 The first START accepted after RST deasserts SHALL operate normally.

Verification (N=4, with the bench modelling the external adder)
REQ-033 X=0x1234, Y=0x4321, CIN=0 -> A sequence 4,3,2,1 over the four ADD cycles; SUM=0x5555, COUT=0, OVF=0; DONE in the cycle after edge k+4.
REQ-034 X=0xFFFF, Y=0x0001, CIN=0 -> SUM=0x0000, COUT=1, OVF=0.
REQ-035 X=0x7FFF, Y=0x0000, CIN=1 -> SUM=0x8000, COUT=0, OVF=1.
REQ-036 X=0x8000, Y=0x8000, CIN=0 -> SUM=0x0000, COUT=1, OVF=1.
REQ-037 A second START with X=0x1111 during ADD of the REQ-033 case -> ignored; SUM=0x5555 and only one DONE pulse.
REQ-038 RST pulsed mid-cycle during the third ADD cycle -> BUSY=0 and SUM=0 immediately with no DONE; a following START with X=0x0001, Y=0x0001 -> SUM=0x0002.

Source files
------------

// File: rtl/nibble_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_ctrl_if
// Brief    : Operand/result bus and external 4-bit adder hookup for the
//            nibble-serial add controller.
// Revision : 1.0  initial release
// ============================================================================
interface nibble_add_ctrl_if #(
  parameter int N = 4
);
  localparam int c_width = 4 * N;

  logic               start;
  logic [c_width-1:0] x;
  logic [c_width-1:0] y;
  logic               cin;
  logic [3:0]         a;
  logic [3:0]         b;
  logic               ci;
  logic [3:0]         s;
  logic               co;
  logic [c_width-1:0] sum;
  logic               cout;
  logic               ovf;
  logic               busy;
  logic               done;

  // The master side also hosts the external ripple-carry adder (s, co).
  modport master (
    output start, x, y, cin, s, co,
    input  a, b, ci, sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, x, y, cin, s, co,
    output a, b, ci, sum, cout, ovf, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/nibble_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_ctrl
// Brief    : Drives an external 4-bit adder one nibble per cycle to add two
//            4*N-bit operands; reports sum, carry-out and signed overflow.
// Revision : 1.0  initial release
// ============================================================================
module nibble_add_ctrl #(
  parameter int N = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  nibble_add_ctrl_if.slave bus
);
  localparam int c_width = 4 * N;
  localparam int c_cnt_w = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_width-1:0] r_x;
  logic [c_width-1:0] r_y;
  logic [c_width-1:0] r_psum;
  logic [c_width-1:0] r_sum;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carry;
  logic               r_x_msb;
  logic               r_y_msb;
  logic               r_cout;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [c_width-1:0] w_psum_next;
  logic               w_last;

  assign w_psum_next = (c_width'(bus.s) << (c_width - 4)) | (r_psum >> 4);
  assign w_last      = (r_cnt == c_cnt_w'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_x_msb <= 1'b0;
      r_y_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_x     <= bus.x;
            r_y     <= bus.y;
            r_carry <= bus.cin;
            r_x_msb <= bus.x[c_width-1];
            r_y_msb <= bus.y[c_width-1];
            r_cnt   <= '0;
            r_psum  <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_psum <= w_psum_next;
          r_x    <= r_x >> 4;
          r_y    <= r_y >> 4;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          if (w_last) begin
            r_sum   <= w_psum_next;
            r_cout  <= bus.co;
            r_ovf   <= (r_x_msb == r_y_msb) && (bus.s[3] != r_x_msb);
            // Carry is parked at zero so ci idles low once the shifters drain.
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_carry <= bus.co;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Shift registers are empty outside ADD, so a/b read zero in IDLE and FIN.
  assign bus.a    = r_x[3:0];
  assign bus.b    = r_y[3:0];
  assign bus.ci   = r_carry;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_nibble_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_add_ctrl
// Brief    : Directed bench for nibble_add_ctrl with an external adder model
//            and a per-cycle reference model of the whole addition.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nibble_add_ctrl_if #(.N(N)) bus ();

  nibble_add_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External 4-bit ripple-carry adder.
  logic [4:0] adder;
  assign adder  = {1'b0, bus.a} + {1'b0, bus.b} + {4'b0, bus.ci};
  assign bus.s  = adder[3:0];
  assign bus.co = adder[4];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_j = -1 idle, 0..N-1 nibble being added, N = done cycle.
  int           m_j;
  logic [W-1:0] m_x, m_y, m_sum;
  logic         m_cin, m_cout, m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_j = -1; m_x = '0; m_y = '0; m_cin = 1'b0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_j == -1) begin
      if (bus.start) begin
        m_j = 0; m_x = bus.x; m_y = bus.y; m_cin = bus.cin;
      end
    end else if (m_j == N - 1) begin
      {m_cout, m_sum} = {1'b0, m_x} + {1'b0, m_y} + (W + 1)'(m_cin);
      m_ovf = (m_x[W-1] == m_y[W-1]) && (m_sum[W-1] != m_x[W-1]);
      m_j = N;
    end else if (m_j == N) begin
      m_j = -1;
    end else begin
      m_j++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic        e_busy;
      logic [3:0]  e_a, e_b;
      logic        e_ci;
      longint      mask, low;
      e_busy = (m_j >= 0) && (m_j < N);
      e_a = 4'd0; e_b = 4'd0; e_ci = 1'b0;
      if (e_busy) begin
        e_a  = 4'((m_x >> (4 * m_j)) & 16'hF);
        e_b  = 4'((m_y >> (4 * m_j)) & 16'hF);
        mask = (64'd1 << (4 * m_j)) - 1;
        low  = (longint'(m_x) & mask) + (longint'(m_y) & mask) + longint'(m_cin);
        e_ci = ((low >> (4 * m_j)) != 0);
      end
      check("busy", bus.busy, e_busy);
      check("done", bus.done, m_j == N);
      check("a", bus.a, e_a);
      check("b", bus.b, e_b);
      check("ci", bus.ci, e_ci);
      check("sum", bus.sum, m_sum);
      check("cout", bus.cout, m_cout);
      check("ovf", bus.ovf, m_ovf);
      if (bus.done) n_done++;
    end
  end

  logic [3:0] a_seq [N];
  int         n_a;

  task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.x = x; bus.y = y; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
    lat = 1; n_a = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy && n_a < N) begin
        a_seq[n_a] = bus.a;
        n_a++;
      end
      @(negedge clk);
      lat++;
    end
    check("done_seen", bus.done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sum", bus.sum, '0);
    check("rst_a", bus.a, 4'd0);
    rst = 1'b0;
    @(negedge clk);

    run_add(16'h1234, 16'h4321, 1'b0, lat);
    check("lat_1234", lat, N + 1);
    check("aseq0", a_seq[0], 4'h4);
    check("aseq1", a_seq[1], 4'h3);
    check("aseq2", a_seq[2], 4'h2);
    check("aseq3", a_seq[3], 4'h1);
    check("sum_1234", bus.sum, 16'h5555);
    check("cout_1234", bus.cout, 1'b0);
    check("ovf_1234", bus.ovf, 1'b0);

    run_add(16'hFFFF, 16'h0001, 1'b0, lat);
    check("sum_ffff", bus.sum, 16'h0000);
    check("cout_ffff", bus.cout, 1'b1);
    check("ovf_ffff", bus.ovf, 1'b0);

    run_add(16'h7FFF, 16'h0000, 1'b1, lat);
    check("sum_7fff", bus.sum, 16'h8000);
    check("cout_7fff", bus.cout, 1'b0);
    check("ovf_7fff", bus.ovf, 1'b1);

    run_add(16'h8000, 16'h8000, 1'b0, lat);
    check("sum_8000", bus.sum, 16'h0000);
    check("cout_8000", bus.cout, 1'b1);
    check("ovf_8000", bus.ovf, 1'b1);

    // A second request during ADD must be dropped.
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 16'h1234; bus.y = 16'h4321; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.x = '0; bus.y = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 16'h1111; bus.y = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0; bus.x = '0; bus.y = '0;
    repeat (8) @(negedge clk);
    check("ignored_done_cnt", n_done, 1);
    check("ignored_sum", bus.sum, 16'h5555);

    // Reset in the middle of the third ADD cycle aborts the addition.
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 16'h0F0F; bus.y = 16'h0101; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.x = '0; bus.y = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_sum", bus.sum, '0);
    check("abort_done", bus.done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", n_done, 0);
    run_add(16'h0001, 16'h0001, 1'b0, lat);
    check("post_rst_lat", lat, N + 1);
    check("post_rst_sum", bus.sum, 16'h0002);
    check("post_rst_cout", bus.cout, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
